// File: rtl/flash_prog_seq.sv
// Command sequencer for the 16-bit parallel flash write engine: expands program/erase requests
// into JEDEC unlock/command bus-write series. Define FLASH_ERASE_EN to build sector erase.
module flash_prog_seq #(
    parameter int unsigned PROG_WAIT   = 20,
    parameter int unsigned ERASE_WAIT  = 1000,
    parameter int unsigned FIN_TIMEOUT = 64,
    parameter logic [31:0] UNLOCK_A1   = 32'h555,
    parameter logic [31:0] UNLOCK_A2   = 32'h2AA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        wr_ce,
    output logic [31:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_fin
);

`ifdef FLASH_ERASE_EN
    localparam int unsigned CNT_MAX = (ERASE_WAIT > FIN_TIMEOUT) ? ERASE_WAIT : FIN_TIMEOUT;
`else
    localparam int unsigned CNT_MAX = (PROG_WAIT > FIN_TIMEOUT) ? PROG_WAIT : FIN_TIMEOUT;
`endif
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [2:0] PROG_LAST = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_FIN, S_DELAY, S_DONE, S_REJECT
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } bus_wr_t;

    function automatic bus_wr_t prog_entry(input logic [2:0] step, input logic [31:0] addr,
                                           input logic [15:0] data);
        case (step)
            3'd0:    prog_entry = '{UNLOCK_A1, 16'h00AA};
            3'd1:    prog_entry = '{UNLOCK_A2, 16'h0055};
            3'd2:    prog_entry = '{UNLOCK_A1, 16'h00A0};
            default: prog_entry = '{addr, data};
        endcase
    endfunction

`ifdef FLASH_ERASE_EN
    localparam logic [2:0] ERASE_LAST = 3'd5;

    function automatic bus_wr_t erase_entry(input logic [2:0] step, input logic [31:0] addr);
        case (step)
            3'd0:    erase_entry = '{UNLOCK_A1, 16'h00AA};
            3'd1:    erase_entry = '{UNLOCK_A2, 16'h0055};
            3'd2:    erase_entry = '{UNLOCK_A1, 16'h0080};
            3'd3:    erase_entry = '{UNLOCK_A1, 16'h00AA};
            3'd4:    erase_entry = '{UNLOCK_A2, 16'h0055};
            default: erase_entry = '{addr, 16'h0030};
        endcase
    endfunction

    logic op_q, op_n;
`endif

    state_t             state, state_n;
    logic [2:0]         step, step_n, last_step;
    logic [CNT_W-1:0]   cnt, cnt_n, delay_load;
    logic [31:0]        addr_q, addr_n, wr_addr_n;
    logic [15:0]        data_q, data_n, wr_data_n;
    bus_wr_t            entry;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            step    <= '0;
            cnt     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
`ifdef FLASH_ERASE_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            step    <= step_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
`ifdef FLASH_ERASE_EN
            op_q    <= op_n;
`endif
        end
    end

`ifdef FLASH_ERASE_EN
    assign last_step  = op_q ? ERASE_LAST : PROG_LAST;
    assign delay_load = op_q ? CNT_W'(ERASE_WAIT) : CNT_W'(PROG_WAIT);
`else
    assign last_step  = PROG_LAST;
    assign delay_load = CNT_W'(PROG_WAIT);
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        step_n    = step;
        cnt_n     = cnt;
        addr_n    = addr_q;
        data_n    = data_q;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        err       = 1'b0;
`ifdef FLASH_ERASE_EN
        op_n      = op_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_n = cmd_addr;
                    data_n = cmd_data;
                    step_n = '0;
`ifdef FLASH_ERASE_EN
                    op_n    = cmd_op;
                    state_n = S_ISSUE;
`else
                    state_n = cmd_op ? S_REJECT : S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                cnt_n   = '0;
                state_n = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                cnt_n = cnt + 1'b1;
                // A completion arriving on the timeout cycle still counts as success.
                if (wr_fin) begin
                    if (step == last_step) begin
                        cnt_n   = delay_load;
                        state_n = S_DELAY;
                    end else begin
                        step_n  = step + 3'd1;
                        state_n = S_ISSUE;
                    end
                end else if (cnt == CNT_W'(FIN_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_DELAY: begin
                if (cnt == '0) state_n = S_DONE;
                else           cnt_n   = cnt - 1'b1;
            end
            S_DONE:   state_n = S_IDLE;
            S_REJECT: begin
                err     = 1'b1;
                state_n = S_IDLE;
            end
            default:  state_n = S_IDLE;
        endcase

`ifdef FLASH_ERASE_EN
        entry = op_n ? erase_entry(step_n, addr_n) : prog_entry(step_n, addr_n, data_n);
`else
        entry = prog_entry(step_n, addr_n, data_n);
`endif
        // Bus address/data are loaded on entry to ISSUE and then held until the next step.
        if (state_n == S_ISSUE) begin
            wr_addr_n = entry.addr;
            wr_data_n = entry.data;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign wr_ce     = (state == S_ISSUE);

endmodule

// File: tb/tb_flash_prog_seq.sv
// Self-checking bench for flash_prog_seq: engine model pops expected bus writes from a scoreboard.
// Handles both builds (FLASH_ERASE_EN defined or not).
module tb_flash_prog_seq;

    localparam int unsigned PROG_WAIT   = 20;
    localparam int unsigned ERASE_WAIT  = 1000;
    localparam int unsigned FIN_TIMEOUT = 64;
    localparam logic [31:0] A1 = 32'h555;
    localparam logic [31:0] A2 = 32'h2AA;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } bus_wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        busy, done, err, wr_ce, wr_fin;
    logic [31:0] wr_addr;
    logic [15:0] wr_data;

    bus_wr_t exp_q[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, ce_count = 0, done_seen = 0, err_seen = 0;
    int last_done_cyc = -1, last_err_cyc = -1;
    int fin_delay = 1;
    bit fin_never = 1'b0, spur_fin = 1'b0;

    flash_prog_seq #(
        .PROG_WAIT(PROG_WAIT), .ERASE_WAIT(ERASE_WAIT), .FIN_TIMEOUT(FIN_TIMEOUT),
        .UNLOCK_A1(A1), .UNLOCK_A2(A2)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done), .err(err),
        .wr_ce(wr_ce), .wr_addr(wr_addr), .wr_data(wr_data), .wr_fin(wr_fin)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write-engine model: checks each wr_ce against the scoreboard and the hold of addr/data,
    // then returns wr_fin fin_delay cycles later (never, when fin_never is set).
    initial begin : engine
        int      wait_left;
        bit      pending, fire;
        bus_wr_t held, exp;
        wait_left = 0;
        pending   = 1'b0;
        held      = '0;
        wr_fin    = 1'b0;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    n_checks++;
                    if (wr_ce !== 1'b0 || wr_addr !== held.addr || wr_data !== held.data) begin
                        n_fail++;
                        $display("FAIL bus_hold: got ce=%b %h/%h required ce=0 %h/%h",
                                 wr_ce, wr_addr, wr_data, held.addr, held.data);
                    end
                    wait_left--;
                    if (wait_left == 0) begin
                        fire    = 1'b1;
                        pending = 1'b0;
                    end
                end
                if (wr_ce === 1'b1) begin
                    ce_count++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL bus_write: got %h/%h required no write", wr_addr, wr_data);
                    end else begin
                        exp = exp_q.pop_front();
                        if (wr_addr !== exp.addr || wr_data !== exp.data) begin
                            n_fail++;
                            $display("FAIL bus_write: got %h/%h required %h/%h",
                                     wr_addr, wr_data, exp.addr, exp.data);
                        end
                    end
                    held      = '{wr_addr, wr_data};
                    pending   = !fin_never;
                    wait_left = fin_delay;
                end
            end
            wr_fin = fire | spur_fin;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (done === 1'b1) begin done_seen++; last_done_cyc = cyc; end
        if (err === 1'b1)  begin err_seen++;  last_err_cyc  = cyc; end
        if (done === 1'b1 || err === 1'b1) begin
            n_checks++;
            if (done === 1'b1 && err === 1'b1) begin
                n_fail++;
                $display("FAIL done_err_exclusive: got done=1 err=1 at cycle %0d, required one", cyc);
            end
        end
    endtask

    task automatic push_series(input logic op, input logic [31:0] a, input logic [15:0] d);
        exp_q.push_back(bus_wr_t'{A1, 16'h00AA});
        exp_q.push_back(bus_wr_t'{A2, 16'h0055});
        if (!op) begin
            exp_q.push_back(bus_wr_t'{A1, 16'h00A0});
            exp_q.push_back(bus_wr_t'{a, d});
        end else begin
            exp_q.push_back(bus_wr_t'{A1, 16'h0080});
            exp_q.push_back(bus_wr_t'{A1, 16'h00AA});
            exp_q.push_back(bus_wr_t'{A2, 16'h0055});
            exp_q.push_back(bus_wr_t'{a, 16'h0030});
        end
    endtask

    // Holds cmd_valid until cmd_ready; acc is the cycle count in the accepting cycle.
    task automatic issue_cmd(input logic op, input logic [31:0] a, input logic [15:0] d,
                             input bit expect_writes, output int acc);
        if (expect_writes) push_series(op, a, d);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        acc       = -1;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            tick();
        end
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready=%b required 1 within 3000 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_outcome(input int limit, output int at, output bit got_done, output bit got_err);
        at       = -1;
        got_done = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done === 1'b1 || err === 1'b1) begin
                at       = cyc;
                got_done = done;
                got_err  = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_data = '0;
        tick();
        tick();
        n_checks++;
        if ({cmd_ready, busy, done, err, wr_ce} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/busy/done/err/ce=%b required 10000",
                     {cmd_ready, busy, done, err, wr_ce});
        end
        n_checks++;
        if (wr_addr !== 32'h0 || wr_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%h required 0/0", wr_addr, wr_data);
        end
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || ce_count != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b ce=%0d required 1 0 0",
                     cmd_ready, busy, ce_count);
        end
    endtask

    task automatic test_program();
        int acc, at, ce0, d0;
        bit gd, ge;
        fin_delay = 1;
        ce0 = ce_count;
        d0  = done_seen;
        issue_cmd(1'b0, 32'h1234, 16'hBEEF, 1'b1, acc);
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_busy: got busy=%b rdy=%b required 1 0", busy, cmd_ready);
        end
        wait_outcome(100, at, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || ge !== 1'b0 || at != acc + 30) begin
            n_fail++;
            $display("FAIL prog_done: got done=%b err=%b at +%0d required done at +30", gd, ge, at - acc);
        end
        tick();
        n_checks++;
        if (ce_count - ce0 != 4 || done_seen - d0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL prog_count: got ce=%0d done=%0d left=%0d required 4 1 0",
                     ce_count - ce0, done_seen - d0, exp_q.size());
        end
    endtask

    task automatic test_slow_engine();
        int acc, at, ce0, d0;
        bit gd, ge;
        fin_delay = 5;
        ce0 = ce_count;
        d0  = done_seen;
        issue_cmd(1'b0, 32'h00AB_CDEF, 16'h1357, 1'b1, acc);
        wait_outcome(200, at, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || at != acc + 4 * 6 + int'(PROG_WAIT) + 2) begin
            n_fail++;
            $display("FAIL slow_done: got done=%b at +%0d required done at +%0d",
                     gd, at - acc, 4 * 6 + PROG_WAIT + 2);
        end
        tick();
        n_checks++;
        if (ce_count - ce0 != 4 || done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL slow_count: got ce=%0d done=%0d required 4 1", ce_count - ce0, done_seen - d0);
        end
        fin_delay = 1;
    endtask

    task automatic test_timeout();
        int acc, at, ce0;
        bit gd, ge;
        fin_never = 1'b1;
        ce0 = ce_count;
        issue_cmd(1'b0, 32'h0000_0042, 16'h5A5A, 1'b1, acc);
        n_checks++;
        if (wr_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_first_ce: got wr_ce=%b required 1", wr_ce);
        end
        wait_outcome(200, at, gd, ge);
        n_checks++;
        if (ge !== 1'b1 || gd !== 1'b0 || at != acc + 1 + int'(FIN_TIMEOUT)) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b done=%b at +%0d after wr_ce required err at +%0d",
                     ge, gd, at - acc - 1, FIN_TIMEOUT);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || ce_count - ce0 != 1) begin
            n_fail++;
            $display("FAIL timeout_recover: got rdy=%b busy=%b ce=%0d required 1 0 1",
                     cmd_ready, busy, ce_count - ce0);
        end
        exp_q.delete();
        fin_never = 1'b0;
    endtask

    task automatic test_erase();
        int acc, ce0;
`ifdef FLASH_ERASE_EN
        int at;
        bit gd, ge;
        fin_delay = 1;
        ce0 = ce_count;
        issue_cmd(1'b1, 32'h8000, 16'hFFFF, 1'b1, acc);
        wait_outcome(1200, at, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || ge !== 1'b0 || at != acc + 6 * 2 + int'(ERASE_WAIT) + 2) begin
            n_fail++;
            $display("FAIL erase_done: got done=%b err=%b at +%0d required done at +%0d",
                     gd, ge, at - acc, 6 * 2 + ERASE_WAIT + 2);
        end
        tick();
        n_checks++;
        if (ce_count - ce0 != 6 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL erase_count: got ce=%0d left=%0d required 6 0", ce_count - ce0, exp_q.size());
        end
`else
        int e0;
        ce0 = ce_count;
        e0  = err_seen;
        issue_cmd(1'b1, 32'h8000, 16'hFFFF, 1'b0, acc);
        n_checks++;
        if (err_seen - e0 != 1 || last_err_cyc != acc + 1) begin
            n_fail++;
            $display("FAIL erase_reject: got err count %0d at +%0d required 1 at +1",
                     err_seen - e0, last_err_cyc - acc);
        end
        tick();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || ce_count != ce0 || err_seen - e0 != 1) begin
            n_fail++;
            $display("FAIL erase_reject_idle: got rdy=%b ce=%0d err=%0d required 1 0 1",
                     cmd_ready, ce_count - ce0, err_seen - e0);
        end
`endif
    endtask

    task automatic test_rst_mid();
        int acc, at, ce0, d0, e0;
        bit gd, ge;
        fin_delay = 8;
        ce0 = ce_count;
        d0  = done_seen;
        e0  = err_seen;
        issue_cmd(1'b0, 32'h0000_7777, 16'hC0DE, 1'b1, acc);
        for (int i = 0; i < 50 && ce_count - ce0 < 2; i++) tick();
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, busy, done, err, wr_ce} !== 5'b10000) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got rdy/busy/done/err/ce=%b required 10000",
                     {cmd_ready, busy, done, err, wr_ce});
        end
        n_checks++;
        if (wr_addr !== 32'h0 || wr_data !== 16'h0 || ce_count - ce0 != 2) begin
            n_fail++;
            $display("FAIL rst_mid_bus: got %h/%h ce=%0d required 0/0 ce=2", wr_addr, wr_data, ce_count - ce0);
        end
        tick();
        rst = 1'b0;
        exp_q.delete();
        fin_delay = 1;
        ce0 = ce_count;
        issue_cmd(1'b0, 32'h0000_0100, 16'h2468, 1'b1, acc);
        wait_outcome(100, at, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || at != acc + 30 || ce_count - ce0 != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_rerun: got done=%b at +%0d ce=%0d required done at +30 ce=4",
                     gd, at - acc, ce_count - ce0);
        end
        n_checks++;
        if (done_seen - d0 != 1 || err_seen - e0 != 0) begin
            n_fail++;
            $display("FAIL rst_mid_pulses: got done=%0d err=%0d required 1 0", done_seen - d0, err_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, at, ce0, d0;
        bit gd, ge;
        fin_delay = 1;
        ce0 = ce_count;
        spur_fin = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        spur_fin = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ce_count != ce0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_spurious: got ce=%0d busy=%b rdy=%b required 0 0 1",
                     ce_count - ce0, busy, cmd_ready);
        end
        d0 = done_seen;
        issue_cmd(1'b0, 32'h0000_0A0A, 16'h1111, 1'b1, acc_a);
        for (int i = 0; i < 50 && ce_count - ce0 < 4; i++) tick();
        tick();
        tick();
        tick();
        spur_fin = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        spur_fin = 1'b0;
        issue_cmd(1'b0, 32'h0000_0B0B, 16'h2222, 1'b1, acc_b);
        n_checks++;
        if (last_done_cyc != acc_a + 30 || acc_b != acc_a + 31) begin
            n_fail++;
            $display("FAIL b2b_first: got done at +%0d, second accept at +%0d required +30 and +31",
                     last_done_cyc - acc_a, acc_b - acc_a);
        end
        wait_outcome(100, at, gd, ge);
        n_checks++;
        if (gd !== 1'b1 || at != acc_b + 30 || done_seen - d0 != 2 || ce_count - ce0 != 8) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b at +%0d dones=%0d ce=%0d required done at +30 2 8",
                     gd, at - acc_b, done_seen - d0, ce_count - ce0);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_slow_engine();
        test_timeout();
        test_erase();
        test_rst_mid();
        test_back_to_back();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
